// File: rtl/ntt_writeback_sequencer.sv
// Write-back sequencer for the NTT core: queues issued address quadruples and pairs them with butterfly results.
// Optional error checking (overflow/underflow/write-count flags) is compiled in with `define WB_ERROR_CHECK_EN.
module ntt_writeback_sequencer #(
  parameter int DW = 24,
  parameter int FD = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic          rd_valid,
  input  logic [6:0]    rd_addr0,
  input  logic [6:0]    rd_addr1,
  input  logic [6:0]    rd_addr2,
  input  logic [6:0]    rd_addr3,
  input  logic          gen_done,
  input  logic          bf_valid,
  input  logic [DW-1:0] bf_data0,
  input  logic [DW-1:0] bf_data1,
  input  logic [DW-1:0] bf_data2,
  input  logic [DW-1:0] bf_data3,
  output logic          wr_en,
  output logic [6:0]    wr_addr0,
  output logic [6:0]    wr_addr1,
  output logic [6:0]    wr_addr2,
  output logic [6:0]    wr_addr3,
  output logic [DW-1:0] wr_data0,
  output logic [DW-1:0] wr_data1,
  output logic [DW-1:0] wr_data2,
  output logic [DW-1:0] wr_data3,
  output logic          busy,
  output logic          done,
  output logic [2:0]    err
);

  localparam int AW = $clog2(FD);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [27:0]     r_fifo_mem [FD];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            r_wr_en;
  logic [27:0]     r_wr_addr;
  logic [4*DW-1:0] r_wr_data;

  logic            w_mode_legal;
  logic            w_start_ok;
  logic            w_active;
  logic            w_empty;
  logic            w_full;
  logic            w_push_req;
  logic            w_pop_req;
  logic            w_push;
  logic            w_pop;
  logic [27:0]     w_push_word;
  logic [27:0]     w_head;

  assign w_mode_legal = (mode == 3'b001) || (mode == 3'b100) ||
                        (mode == 3'b010) || (mode == 3'b110);
  assign w_start_ok   = (r_state == S_IDLE) && start && w_mode_legal;
  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_push_req   = w_active && rd_valid;
  assign w_pop_req    = w_active && bf_valid;
  // A pop alongside a push frees a slot, so a full FIFO still accepts; an empty one forwards the push.
  assign w_push       = w_push_req && (!w_full || w_pop_req);
  assign w_pop        = w_pop_req && (!w_empty || w_push_req);
  assign w_push_word  = {rd_addr3, rd_addr2, rd_addr1, rd_addr0};
  assign w_head       = w_empty ? w_push_word : r_fifo_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_state_next = S_RUN;
      end
      S_RUN:   if (gen_done) w_state_next = S_DRAIN;
      S_DRAIN: if (w_empty && !r_wr_en && !rd_valid) w_state_next = S_DONE;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn || w_start_ok) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wptr] <= w_push_word;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= w_head;
        r_wr_data <= {bf_data3, bf_data2, bf_data1, bf_data0};
      end
    end
  end

  assign wr_en = r_wr_en;
  assign {wr_addr3, wr_addr2, wr_addr1, wr_addr0} = r_wr_addr;
  assign {wr_data3, wr_data2, wr_data1, wr_data0} = r_wr_data;

`ifdef WB_ERROR_CHECK_EN
  logic [8:0] r_wr_cnt;
  logic [8:0] r_exp_cnt;
  logic [2:0] r_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_exp_cnt <= '0;
      r_err     <= '0;
    end else if (w_start_ok) begin
      r_wr_cnt  <= '0;
      r_exp_cnt <= mode[1] ? 9'd32 : 9'd256;
      r_err     <= '0;
    end else begin
      if (w_pop && (r_wr_cnt != 9'd511)) r_wr_cnt <= r_wr_cnt + 9'd1;
      if (w_push_req && w_full && !w_pop_req)   r_err[0] <= 1'b1;
      if (w_pop_req && w_empty && !w_push_req)  r_err[1] <= 1'b1;
      // The count is final on entry to DONE, so the flag is valid alongside the done pulse.
      if ((r_state == S_DRAIN) && (w_state_next == S_DONE) && (r_wr_cnt != r_exp_cnt))
        r_err[2] <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 3'b000;
`endif

endmodule
